// File: rtl/control_fsm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ctrl_pkg                                                     |
// | Description : Shared widths, opcode and state encodings, and ALU select    |
// |               constants for the processor control unit.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ctrl_pkg;

    localparam int INSTR_W = 16;   // instruction width
    localparam int DADDR_W = 8;    // data-memory address width
    localparam int RADDR_W = 4;    // register-file address width
    localparam int ALUS_W  = 3;    // ALU function-select width

    // Opcode field IR[15:12]; any other code behaves as NOOP.
    typedef enum logic [3:0] {
        OP_NOOP  = 4'b0000,
        OP_STORE = 4'b0001,
        OP_LOAD  = 4'b0010,
        OP_ADD   = 4'b0011,
        OP_SUB   = 4'b0100,
        OP_HALT  = 4'b0101
    } opcode_t;

    // Values double as the OutState debug encoding. ST_NOOP is reserved:
    // DECODE routes NOOP straight back to FETCH.
    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_LOAD_A = 4'd4,
        ST_LOAD_B = 4'd5,
        ST_STORE  = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

    localparam logic [ALUS_W-1:0] ALU_PASS = 3'b000;
    localparam logic [ALUS_W-1:0] ALU_ADD  = 3'b001;
    localparam logic [ALUS_W-1:0] ALU_SUB  = 3'b010;

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/control_fsm_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ctrl_if                                                      |
// | Description : Control bus between the control unit and the datapath.       |
// |   IR                         instruction from the instruction register     |
// |   PC_clr / PC_up             program-counter clear / increment             |
// |   IR_ld                      instruction-register load                     |
// |   D_addr / D_wr              data-memory address / write enable            |
// |   RF_s, RF_W_addr, RF_W_en   register-file write mux, address, enable      |
// |   RF_Ra_addr / RF_Rb_addr    register-file read addresses                  |
// |   ALU_s0                     ALU function select                           |
// |   OutState                   current state encoding (debug)                |
// |   master = control unit, slave = datapath                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface ctrl_if
    import ctrl_pkg::*;
#(
    parameter int INSTR_W_P = INSTR_W,
    parameter int DADDR_W_P = DADDR_W,
    parameter int RADDR_W_P = RADDR_W,
    parameter int ALUS_W_P  = ALUS_W
);
    logic [INSTR_W_P-1:0] IR;
    logic                 PC_clr;
    logic                 PC_up;
    logic                 IR_ld;
    logic [DADDR_W_P-1:0] D_addr;
    logic                 D_wr;
    logic                 RF_s;
    logic [RADDR_W_P-1:0] RF_W_addr;
    logic                 RF_W_en;
    logic [RADDR_W_P-1:0] RF_Ra_addr;
    logic [RADDR_W_P-1:0] RF_Rb_addr;
    logic [ALUS_W_P-1:0]  ALU_s0;
    logic [3:0]           OutState;

    modport master (
        input  IR,
        output PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, OutState
    );

    modport slave (
        output IR,
        input  PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, OutState
    );
endinterface : ctrl_if
`default_nettype wire

// File: rtl/control_fsm_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ctrl_decode                                                  |
// | Description : Combinational Moore output decode: (state, IR operand        |
// |               fields) -> all control outputs. Outputs not used by a state  |
// |               are held at 0.                                               |
// |   state      current FSM state                                             |
// |   IR_fields  IR[11:0], the operand fields (opcode not needed here)         |
// |   others     control outputs, same meaning as on ctrl_if                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ctrl_decode
    import ctrl_pkg::*;
(
    input  state_t                   state,
    input  logic [INSTR_W-5:0]       IR_fields,
    output logic                     PC_clr,
    output logic                     PC_up,
    output logic                     IR_ld,
    output logic [DADDR_W-1:0]       D_addr,
    output logic                     D_wr,
    output logic                     RF_s,
    output logic [RADDR_W-1:0]       RF_W_addr,
    output logic                     RF_W_en,
    output logic [RADDR_W-1:0]       RF_Ra_addr,
    output logic [RADDR_W-1:0]       RF_Rb_addr,
    output logic [ALUS_W-1:0]        ALU_s0
);

    always_comb begin
        PC_clr     = 1'b0;
        PC_up      = 1'b0;
        IR_ld      = 1'b0;
        D_addr     = '0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = '0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = '0;
        RF_Rb_addr = '0;
        ALU_s0     = ALU_PASS;

        case (state)
            ST_INIT: begin
                PC_clr = 1'b1;
            end
            ST_FETCH: begin
                // IR captures mem[PC] and the PC advances on the same edge.
                PC_up = 1'b1;
                IR_ld = 1'b1;
            end
            ST_LOAD_A: begin
                // Address presented a cycle early to cover the synchronous read.
                D_addr    = IR_fields[11:4];
                RF_W_addr = IR_fields[3:0];
                RF_s      = 1'b1;
            end
            ST_LOAD_B: begin
                D_addr    = IR_fields[11:4];
                RF_W_addr = IR_fields[3:0];
                RF_s      = 1'b1;
                RF_W_en   = 1'b1;
            end
            ST_STORE: begin
                RF_Ra_addr = IR_fields[11:8];
                D_addr     = IR_fields[7:0];
                D_wr       = 1'b1;
            end
            ST_ADD, ST_SUB: begin
                RF_Ra_addr = IR_fields[11:8];
                RF_Rb_addr = IR_fields[7:4];
                RF_W_addr  = IR_fields[3:0];
                RF_W_en    = 1'b1;
                ALU_s0     = (state == ST_SUB) ? ALU_SUB : ALU_ADD;
            end
            default: ;
        endcase
    end

endmodule : ctrl_decode
`default_nettype wire

// File: rtl/control_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : control_fsm                                                  |
// | Description : Fetch/decode/execute control unit. Holds the state register  |
// |               and next-state logic; output decode lives in ctrl_decode.    |
// |   Clk     system clock, rising edge                                        |
// |   ResetN  synchronous active-low reset                                     |
// |   bus     ctrl_if master: IR in, PC/IR/memory/RF/ALU controls out          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module control_fsm
    import ctrl_pkg::*;
(
    input  wire    Clk,
    input  wire    ResetN,
    ctrl_if.master bus
);

    state_t r_state;
    state_t w_next;

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT:   w_next = ST_FETCH;
            ST_FETCH:  w_next = ST_DECODE;
            ST_DECODE: begin
                // Opcode is only looked at here; undefined codes act as NOOP.
                case (bus.IR[INSTR_W-1 -: 4])
                    OP_LOAD:  w_next = ST_LOAD_A;
                    OP_STORE: w_next = ST_STORE;
                    OP_ADD:   w_next = ST_ADD;
                    OP_SUB:   w_next = ST_SUB;
                    OP_HALT:  w_next = ST_HALT;
                    default:  w_next = ST_FETCH;
                endcase
            end
            ST_LOAD_A: w_next = ST_LOAD_B;
            ST_LOAD_B: w_next = ST_FETCH;
            ST_STORE:  w_next = ST_FETCH;
            ST_ADD:    w_next = ST_FETCH;
            ST_SUB:    w_next = ST_FETCH;
            ST_HALT:   w_next = ST_HALT;
            // Reserved/unused encodings recover through INIT.
            default:   w_next = ST_INIT;
        endcase
    end

    assign bus.OutState = r_state;

    ctrl_decode u_decode (
        .state      (r_state),
        .IR_fields  (bus.IR[INSTR_W-5:0]),
        .PC_clr     (bus.PC_clr),
        .PC_up      (bus.PC_up),
        .IR_ld      (bus.IR_ld),
        .D_addr     (bus.D_addr),
        .D_wr       (bus.D_wr),
        .RF_s       (bus.RF_s),
        .RF_W_addr  (bus.RF_W_addr),
        .RF_W_en    (bus.RF_W_en),
        .RF_Ra_addr (bus.RF_Ra_addr),
        .RF_Rb_addr (bus.RF_Rb_addr),
        .ALU_s0     (bus.ALU_s0)
    );

endmodule : control_fsm
`default_nettype wire

// File: tb/tb_control_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_control_fsm                                               |
// | Description : Self-checking bench for control_fsm. A per-cycle vector      |
// |               table ({ResetN, IR, expected outputs}) walks reset, LOAD,    |
// |               ADD, SUB, STORE, NOOP and reset-mid-LOAD; hand sequences     |
// |               cover HALT hold and reset out of HALT.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_control_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_clr;
        logic       pc_up;
        logic       ir_ld;
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] wa;
        logic       wen;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] alu;
    } outs_t;

    typedef struct {
        logic        rstn;
        logic [15:0] ir;
        outs_t       exp;
    } vec_t;

    logic Clk;
    logic ResetN;
    int   n_tests;
    int   n_fail;
    vec_t vecs[$];

    ctrl_if bus ();

    control_fsm dut (
        .Clk    (Clk),
        .ResetN (ResetN),
        .bus    (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic outs_t mk(input logic [3:0] st, input logic clr, input logic up,
                                 input logic ld, input logic [7:0] da, input logic dwr,
                                 input logic rfs, input logic [3:0] wa, input logic wen,
                                 input logic [3:0] ra, input logic [3:0] rb,
                                 input logic [2:0] alu);
        outs_t o;
        o.st = st; o.pc_clr = clr; o.pc_up = up; o.ir_ld = ld; o.d_addr = da;
        o.d_wr = dwr; o.rf_s = rfs; o.wa = wa; o.wen = wen; o.ra = ra; o.rb = rb;
        o.alu = alu;
        return o;
    endfunction

    // Common expected patterns
    function automatic outs_t o_init();   return mk(4'd0, 1,0,0, 8'h00,0,0, 4'd0,0, 4'd0,4'd0, 3'd0); endfunction
    function automatic outs_t o_fetch();  return mk(4'd1, 0,1,1, 8'h00,0,0, 4'd0,0, 4'd0,4'd0, 3'd0); endfunction
    function automatic outs_t o_decode(); return mk(4'd2, 0,0,0, 8'h00,0,0, 4'd0,0, 4'd0,4'd0, 3'd0); endfunction
    function automatic outs_t o_halt();   return mk(4'd9, 0,0,0, 8'h00,0,0, 4'd0,0, 4'd0,4'd0, 3'd0); endfunction

    function automatic outs_t sample();
        outs_t o;
        o.st = bus.OutState; o.pc_clr = bus.PC_clr; o.pc_up = bus.PC_up;
        o.ir_ld = bus.IR_ld; o.d_addr = bus.D_addr; o.d_wr = bus.D_wr;
        o.rf_s = bus.RF_s; o.wa = bus.RF_W_addr; o.wen = bus.RF_W_en;
        o.ra = bus.RF_Ra_addr; o.rb = bus.RF_Rb_addr; o.alu = bus.ALU_s0;
        return o;
    endfunction

    task automatic add(input logic rstn, input logic [15:0] ir, input outs_t exp);
        vec_t v;
        v.rstn = rstn; v.ir = ir; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input outs_t exp);
        outs_t act;
        act = sample();
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got st=%0d clr=%b up=%b ld=%b da=%h dwr=%b rfs=%b wa=%h wen=%b ra=%h rb=%h alu=%b, want st=%0d clr=%b up=%b ld=%b da=%h dwr=%b rfs=%b wa=%h wen=%b ra=%h rb=%h alu=%b",
                     name, act.st, act.pc_clr, act.pc_up, act.ir_ld, act.d_addr, act.d_wr,
                     act.rf_s, act.wa, act.wen, act.ra, act.rb, act.alu,
                     exp.st, exp.pc_clr, exp.pc_up, exp.ir_ld, exp.d_addr, exp.d_wr,
                     exp.rf_s, exp.wa, exp.wen, exp.ra, exp.rb, exp.alu);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        ResetN  = 1'b0;
        bus.IR  = 16'h0000;

        // Each row: inputs held for one cycle, outputs expected in that cycle.
        add(1, 16'h0000, o_init());                                                   // after reset
        add(1, 16'h2A53, o_fetch());
        add(1, 16'h2A53, o_decode());
        add(1, 16'h2A53, mk(4'd4, 0,0,0, 8'hA5,0,1, 4'd3,0, 4'd0,4'd0, 3'd0));         // LOAD_A
        add(1, 16'h2A53, mk(4'd5, 0,0,0, 8'hA5,0,1, 4'd3,1, 4'd0,4'd0, 3'd0));         // LOAD_B
        add(1, 16'h3124, o_fetch());                                                  // 4 cycles after prev FETCH
        add(1, 16'h3124, o_decode());
        add(1, 16'h3124, mk(4'd7, 0,0,0, 8'h00,0,0, 4'd4,1, 4'd1,4'd2, 3'b001));       // ADD
        add(1, 16'h4124, o_fetch());
        add(1, 16'h4124, o_decode());
        add(1, 16'h4124, mk(4'd8, 0,0,0, 8'h00,0,0, 4'd4,1, 4'd1,4'd2, 3'b010));       // SUB
        add(1, 16'h1706, o_fetch());
        add(1, 16'h1706, o_decode());
        add(1, 16'h1706, mk(4'd6, 0,0,0, 8'h06,1,0, 4'd0,0, 4'd7,4'd0, 3'd0));         // STORE
        add(1, 16'h0000, o_fetch());
        add(1, 16'h0000, o_decode());                                                 // NOOP
        add(1, 16'hF000, o_fetch());
        add(1, 16'hF000, o_decode());                                                 // undefined -> NOOP
        add(1, 16'h5000, o_fetch());                                                  // IR ignored in FETCH
        add(1, 16'h2A53, o_decode());
        add(0, 16'h2A53, mk(4'd4, 0,0,0, 8'hA5,0,1, 4'd3,0, 4'd0,4'd0, 3'd0));         // reset in LOAD_A
        add(1, 16'h2A53, o_init());                                                   // aborted, no RF_W_en
        add(1, 16'h5000, o_fetch());
        add(1, 16'h5000, o_decode());

        repeat (2) @(posedge Clk);

        foreach (vecs[i]) begin
            @(negedge Clk);
            ResetN = vecs[i].rstn;
            bus.IR = vecs[i].ir;
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // HALT holds with no strobes for 20 cycles.
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            bus.IR = (k[0]) ? 16'h3124 : 16'h2A53;
            #1;
            check($sformatf("halt%0d", k), o_halt());
        end

        // One reset edge exits HALT.
        @(negedge Clk);
        ResetN = 1'b0;
        #1;
        check("halt_pre_reset", o_halt());
        @(negedge Clk);
        ResetN = 1'b1;
        bus.IR = 16'h0000;
        #1;
        check("halt_reset_init", o_init());
        @(negedge Clk);
        #1;
        check("halt_reset_fetch", o_fetch());
        @(negedge Clk);
        #1;
        check("halt_reset_decode", o_decode());
        @(negedge Clk);
        #1;
        check("after_noop_fetch", o_fetch());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_control_fsm
`default_nettype wire

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Processor control unit: the fetch/decode/execute state machine that sits directly upstream of the program counter.
- Drives PC_clr / PC_up to the PC and IR_ld to the instruction register.
- Decodes the 16-bit instruction in IR and drives data-memory, register-file and ALU controls.
- Moore-style: every control output is a combinational function of the current state and, during execute states, the IR fields.

Parameters:
INSTR_W, 16, instruction width
DADDR_W, 8, data-memory address width
RADDR_W, 4, register-file address width
ALUS_W, 3, ALU function-select width

Ports:
Clk  input  1  system clock, all state changes on rising edge
ResetN  input  1  synchronous active-low reset, sampled on rising edge of Clk
IR  input  INSTR_W  current instruction from the instruction register
PC_clr  output  1  clears the program counter
PC_up  output  1  increments the program counter
IR_ld  output  1  loads the instruction register from instruction memory
D_addr  output  DADDR_W  data-memory address
D_wr  output  1  data-memory write enable
RF_s  output  1  register-file write mux select: 1 = data memory, 0 = ALU
RF_W_addr  output  RADDR_W  register-file write address
RF_W_en  output  1  register-file write enable
RF_Ra_addr  output  RADDR_W  register-file read port A address
RF_Rb_addr  output  RADDR_W  register-file read port B address
ALU_s0  output  ALUS_W  ALU function select
OutState  output  4  current state encoding, for display and debug

Behaviour:
- Reset:
  - ResetN low at a rising edge puts the state in INIT on that edge, regardless of the current state.
  - Outputs then follow INIT: PC_clr=1, all other outputs 0.
- Opcode field IR[15:12]: NOOP=0000, STORE=0001, LOAD=0010, ADD=0011, SUB=0100, HALT=0101. Every other code is treated as NOOP.
- Field use by instruction:
  - LOAD: D_addr=IR[11:4], RF_W_addr=IR[3:0].
  - STORE: RF_Ra_addr=IR[11:8], D_addr=IR[7:0].
  - ADD/SUB: Ra=IR[11:8], Rb=IR[7:4], RF_W_addr=IR[3:0].
- State transitions and outputs (any output not listed is 0):
  - INIT -> FETCH. PC_clr=1.
  - FETCH -> DECODE. PC_up=1, IR_ld=1; IR captures mem[PC] and the PC advances on the same edge.
  - DECODE -> LOAD_A / STORE / ADD / SUB / HALT / FETCH (NOOP), selected by opcode.
  - LOAD_A -> LOAD_B. D_addr and RF_W_addr driven, RF_s=1. This state absorbs the one-cycle synchronous memory read.
  - LOAD_B -> FETCH. Same address outputs as LOAD_A, RF_s=1, RF_W_en=1.
  - STORE -> FETCH. D_addr and RF_Ra_addr driven, D_wr=1 for exactly one cycle.
  - ADD -> FETCH. Ra, Rb and RF_W_addr driven, ALU_s0=001, RF_s=0, RF_W_en=1.
  - SUB -> FETCH. Same as ADD but ALU_s0=010.
  - HALT -> HALT. All outputs 0; only reset exits this state.
- Instruction latency in cycles, including FETCH: NOOP 2, STORE/ADD/SUB 3, LOAD 4.
- Every write strobe (D_wr, RF_W_en) and every PC strobe (PC_clr, PC_up) is high for exactly one cycle per instruction.
- Reset asserted mid-instruction aborts the instruction on the next edge. Strobes already high in the current cycle still take effect at that edge; no new strobe is issued afterwards.
- PC wrap-around (127 -> 0) is the PC's job. This block keeps fetching across the wrap.
- IR is sampled only in DECODE and in execute states. IR changes during FETCH are ignored.
- OutState encoding: INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9. DECODE routes NOOP/undefined opcodes straight to FETCH, so OutState=3 is reserved and never produced.

Decomposition:
- Package ctrl_pkg holds:
  - opcode_t enum (6 codes);
  - state_t enum, 4-bit, values as above;
  - ALU select constants ALU_PASS=000, ALU_ADD=001, ALU_SUB=010.
- Optional sub-module ctrl_decode: purely combinational, (state_t, IR) -> all control outputs.
- control_fsm keeps only the state register and the next-state logic.

Test Plan:
- Reset: hold ResetN=0 for 2 edges, release -> OutState=0 with PC_clr=1 for one cycle, then OutState=1 with PC_up=1 and IR_ld=1.
- LOAD: IR=16'h2A53 at DECODE -> LOAD_A then LOAD_B. D_addr=8'hA5 and RF_W_addr=3 in both states; RF_W_en=1 and RF_s=1 in LOAD_B only; back in FETCH 4 cycles after the previous FETCH.
- ADD then SUB:
  - IR=16'h3124 -> Ra=1, Rb=2, RF_W_addr=4, ALU_s0=001, RF_W_en=1 for one cycle.
  - IR=16'h4124 -> identical except ALU_s0=010.
- STORE and NOOP:
  - IR=16'h1706 -> RF_Ra_addr=7, D_addr=8'h06, D_wr=1 for exactly one cycle.
  - IR=16'h0000 and IR=16'hF000 -> DECODE returns to FETCH with no strobes.
- HALT: IR=16'h5000 -> OutState=9 held for 20 cycles with PC_up=0, D_wr=0, RF_W_en=0. Then ResetN=0 for one edge -> OutState=0.
- Reset mid-LOAD: drive ResetN=0 while in LOAD_A -> next state INIT, RF_W_en never asserted, PC_clr=1 once ResetN returns high.
